// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the FSM state encoding, default geometry and the tag-width helper.
package icache_pkg;

  localparam int unsigned INDEX_W_DEFAULT = 6;
  localparam int unsigned OFF_W_DEFAULT   = 2;

  // FSM state encoding
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  // Tag bits left over after byte, word-offset and index bits of a 32-bit address.
  function automatic int unsigned tag_width(input int unsigned index_w, input int unsigned off_w);
    return 30 - index_w - off_w;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset (clears valid bits only)
//   rd_index/rd_off/rd_tag   combinational lookup address; hit/inst are the result
//   line_we/line_valid       write tag and valid bit of line wr_index
//   wr_tag                   tag written with line_we
//   data_we/wr_off/wr_data   write one data word of line wr_index
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_W = INDEX_W_DEFAULT,
  parameter int unsigned OFF_W   = OFF_W_DEFAULT,
  localparam int unsigned TAG_W  = tag_width(INDEX_W, OFF_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [OFF_W-1:0]   rd_off,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [31:0]        inst,
  input  logic               line_we,
  input  logic               line_valid,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               data_we,
  input  logic [OFF_W-1:0]   wr_off,
  input  logic [31:0]        wr_data
);

  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned WORDS = 2 ** OFF_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[wr_index] <= line_valid;
    end
  end

  // Tag and data need no reset: a line is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[wr_index] <= wr_tag;
    end
    if (data_we) begin
      data_q[{wr_index, wr_off}] <= wr_data;
    end
  end

  assign hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign inst = hit ? data_q[{rd_index, rd_off}] : '0;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache. Answers pc lookups combinationally and refills a
// missing line word-by-word from the memory controller.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   rdy                  global enable; 0 freezes all state
//   pc                   fetch address; hit/inst are the combinational lookup result
//   mem_req, mem_addr    registered refill word request and its word address
//   mem_ack, mem_data    returned word, consumed on an edge with rdy=1 in REFILL
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_W = INDEX_W_DEFAULT,
  parameter int unsigned OFF_W   = OFF_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  output logic        hit,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int unsigned TAG_W  = tag_width(INDEX_W, OFF_W);
  localparam int unsigned IDX_LO = OFF_W + 2;
  localparam int unsigned TAG_LO = INDEX_W + OFF_W + 2;
  localparam logic [OFF_W-1:0] CNT_LAST = '1;

  logic [0:0]         state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_d;
  logic [31:0]        mem_addr_d;

  logic               line_we, line_valid, data_we;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;

  logic               unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  icache_array #(
    .INDEX_W (INDEX_W),
    .OFF_W   (OFF_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (pc[TAG_LO-1:IDX_LO]),
    .rd_off     (pc[IDX_LO-1:2]),
    .rd_tag     (pc[31:TAG_LO]),
    .hit        (hit),
    .inst       (inst),
    .line_we    (line_we),
    .line_valid (line_valid),
    .wr_index   (wr_index),
    .wr_tag     (wr_tag),
    .data_we    (data_we),
    .wr_off     (cnt_q),
    .wr_data    (mem_data)
  );

  // During a refill the line's index and tag are taken from mem_addr: it stays inside the
  // latched line because cnt never wraps, so no separate base register is needed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    line_we    = 1'b0;
    line_valid = 1'b0;
    data_we    = 1'b0;
    wr_index   = mem_addr[TAG_LO-1:IDX_LO];
    wr_tag     = mem_addr[31:TAG_LO];
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            // Invalidate the victim now so it cannot hit with partially written data.
            line_we    = 1'b1;
            wr_index   = pc[TAG_LO-1:IDX_LO];
            wr_tag     = pc[31:TAG_LO];
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {pc[31:IDX_LO], {IDX_LO{1'b0}}};
            state_d    = REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            data_we = 1'b1;
            if (cnt_q == CNT_LAST) begin
              line_we    = 1'b1;
              line_valid = 1'b1;
              mem_req_d  = 1'b0;
              state_d    = IDLE;
            end else begin
              cnt_d      = cnt_q + 1'b1;
              mem_addr_d = mem_addr + 32'd4;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a line-level reference model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, hit, mem_req, mem_ack;
  logic [31:0] pc, inst, mem_addr, mem_data;

  icache #(
    .INDEX_W (6),
    .OFF_W   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .pc       (pc),
    .hit      (hit),
    .inst     (inst),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        h;
    logic [31:0] i;
    logic        r;
    logic [31:0] a;
  } look_t;

  look_t       look_q[$];
  logic [31:0] addr_q[$];
  bit          mon_en = 1'b0;

  // Reference model: which line base each index holds, plus the refill in flight.
  bit          lv[64];
  logic [21:0] lt[64];
  bit          busy, ack_pend;
  logic [31:0] rbase, maddr;
  int          done;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0:   return 32'h00000013;
      32'h4:   return 32'h00100093;
      32'h8:   return 32'h00200113;
      32'hC:   return 32'h00300193;
      default: return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) lv[i] = 1'b0;
    busy     = 1'b0;
    ack_pend = 1'b0;
    maddr    = '0;
    rbase    = '0;
    done     = 0;
  endtask

  // One cycle of stimulus: drive inputs at the falling edge, queue what the DUT must show,
  // then advance the model past the coming rising edge.
  task automatic step(input logic [31:0] p, input bit r, input bit want_ack);
    logic [5:0]  idx;
    logic [21:0] tg;
    bit          eh;
    look_t       e;
    @(negedge clk);
    pc       = p;
    rdy      = r;
    mem_ack  = busy && (ack_pend || want_ack);
    ack_pend = mem_ack;
    mem_data = mem_ack ? mem_word(rbase + 32'(4 * done)) : 32'hDEADBEEF;
    idx = p[9:4];
    tg  = p[31:10];
    eh  = lv[idx] && (lt[idx] == tg);
    e.h = eh;
    e.i = eh ? mem_word(p) : 32'h0;
    e.r = busy;
    e.a = maddr;
    look_q.push_back(e);
    if (r) begin
      if (busy && mem_ack) begin
        addr_q.push_back(rbase + 32'(4 * done));
        done++;
        ack_pend = 1'b0;
        if (done == 4) begin
          lv[rbase[9:4]] = 1'b1;
          lt[rbase[9:4]] = rbase[31:10];
          busy = 1'b0;
        end else begin
          maddr = maddr + 32'd4;
        end
      end else if (!busy && !eh) begin
        busy    = 1'b1;
        rbase   = {p[31:4], 4'h0};
        maddr   = rbase;
        done    = 0;
        lv[idx] = 1'b0;
      end
    end
  endtask

  task automatic run(input logic [31:0] p, input int n);
    for (int k = 0; k < n; k++) step(p, 1'b1, 1'b1);
  endtask

  // Monitor: checks lookup outputs every cycle and each consumed memory handshake.
  initial begin
    look_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && look_q.size() > 0) begin
        e = look_q.pop_front();
        chk("hit", 32'(hit), 32'(e.h));
        chk("inst", inst, e.i);
        chk("mem_req", 32'(mem_req), 32'(e.r));
        chk("mem_addr_level", mem_addr, e.a);
      end
      if (mon_en && rdy && mem_ack && mem_req) begin
        if (addr_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else chk("ack_addr", mem_addr, addr_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] p;
    rst      = 1'b0;
    rdy      = 1'b0;
    pc       = '0;
    mem_ack  = 1'b0;
    mem_data = '0;
    model_reset();
    #2;
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    #6;
    rst    = 1'b1;
    mon_en = 1'b1;

    run(32'h0, 6);                  // cold miss, then hit on word 0
    run(32'h8, 1);
    run(32'h1C, 6);                 // mid-line miss
    run(32'h400, 6);                // conflict on index 0
    run(32'h0, 2);                  // miss on 0x0 again ...
    run(32'h20, 4);                 // ... redirected while the refill completes
    run(32'h20, 6);
    run(32'h0, 1);
    run(32'h40, 2);                 // stall with ack pending at cnt=1
    for (int k = 0; k < 3; k++) step(32'h40, 1'b0, 1'b1);
    run(32'h40, 5);

    // Asynchronous reset after two acks of a refill.
    run(32'h400, 3);
    @(negedge clk);
    mem_ack = 1'b0;
    rdy     = 1'b0;
    #3;
    rst = 1'b0;
    pc  = 32'h10;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    chk("async_rst_hit", 32'(hit), 32'd0);
    chk("async_rst_inst", inst, 32'd0);
    model_reset();
    rst = 1'b1;
    run(32'h0, 6);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) p = $urandom;
      else p = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
               | 32'($urandom_range(0, 15));
      step(p, $urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    #5;
    chk("look_q_drained", 32'(look_q.size()), 32'd0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch stage and the memory controller. Answers the fetch stage's per-cycle `pc` lookup combinationally with `hit`/`inst`. On a miss it refills the whole line word-by-word from the memory controller, then resumes answering hits. Only the memory controller writes the array; the fetch stage only reads it.

## Interface
- `INDEX_W`, 6: index bits; the cache holds 2^INDEX_W lines.
- `OFF_W`, 2: word-offset bits; `LINE_WORDS` = 2^OFF_W words per line.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `rdy`  in  1  global enable; when 0, all state is frozen.
- `pc`  in  32  fetch address from the fetch stage; bits [1:0] are ignored.
- `hit`  out  1  combinational: the word at `pc` is present in the cache.
- `inst`  out  32  combinational: the cached word at `pc`; 0 when `hit`=0.
- `mem_req`  out  1  registered: refill word request is pending.
- `mem_addr`  out  32  registered: word-aligned address of the requested word.
- `mem_ack`  in  1  memory controller: `mem_data` is valid this cycle.
- `mem_data`  in  32  returned word.

## Operation
- Address split:
  - offset = `pc[OFF_W+1:2]`
  - index = `pc[OFF_W+INDEX_W+1:OFF_W+2]`
  - tag = the remaining upper bits.
- Hit condition: `hit` = `valid[index]` && `tag_ram[index]`==tag. It is independent of FSM state. Lines other than the one being refilled keep hitting during a refill.
- FSM states: IDLE, REFILL.
- IDLE, with `rdy`=1 and `hit`=0:
  - latch `base` = `pc` with offset and byte bits cleared;
  - latch the index;
  - clear `valid[index]`;
  - set `cnt`=0, `mem_req`=1, `mem_addr`=`base`;
  - go to REFILL.
- REFILL, with `rdy`=1 and `mem_ack`=1:
  - write `mem_data` into `data[idx][cnt]`;
  - if `cnt`==LINE_WORDS-1: write the tag, set `valid[idx]`=1, set `mem_req`=0, go to IDLE;
  - otherwise: `cnt`+1, `mem_addr`+4, keep `mem_req`=1.
- Once started, a refill always completes for its latched line. Changes on `pc` during REFILL have no effect on it.
- `mem_ack` is sampled only when `rdy`=1 and state is REFILL. The controller holds `mem_ack`/`mem_data` until it sees a sampling edge.
- Arithmetic: `cnt` is OFF_W bits and never wraps within a refill. `mem_addr` increments by 4 modulo 2^32.
- `rdy`=0: FSM, `cnt`, arrays and outputs are frozen. `hit`/`inst` still follow `pc` combinationally.
- Reset (asynchronous, any state, including mid-refill):
  - state=IDLE, `cnt`=0, `mem_req`=0, `mem_addr`=0;
  - every `valid` bit = 0, so `hit`=0 and `inst`=0.
  - Tag and data contents need not be reset.

## Timing
- Hit latency: 0 cycles; same cycle as `pc`.
- Miss:
  - miss seen at edge N;
  - `mem_req`/`mem_addr` valid from cycle N+1;
  - each accepted ack advances `mem_addr` on the same edge;
  - last ack at edge M;
  - `hit`=1 for the same `pc` in cycle M+1.
- Minimum miss penalty with zero-wait memory: LINE_WORDS+1 cycles.
- At most one outstanding refill. No new miss is started while in REFILL.
- Ack and miss on the same edge: impossible, since ack is only consumed in REFILL.

## Structure
- Shared package:
  - FSM state encoding (IDLE, REFILL);
  - default INDEX_W/OFF_W;
  - a tag-width expression, 30-INDEX_W-OFF_W.
- One sub-module, `icache_array`:
  - valid/tag/data storage;
  - combinational read port driving `hit`/`inst`;
  - one synchronous write port for word, tag and valid;
  - asynchronous clear of all valid bits.
- FSM and counter live in `icache`.

## Test plan
- Cold miss:
  - reset, then `pc`=0x0 → `hit`=0;
  - next cycle `mem_req`=1, `mem_addr`=0x0;
  - acks 0x00000013, 0x00100093, 0x00200113, 0x00300193 → `mem_addr` steps 0x4, 0x8, 0xC;
  - cycle after the 4th ack, `hit`=1 with `inst`=0x00000013;
  - `pc`=0x8 → `inst`=0x00200113.
- Mid-line miss: `pc`=0x1C → refill starts at `mem_addr`=0x10, ends at 0x1C; afterwards `pc`=0x1C returns the 4th word.
- Conflict:
  - after the 0x0 fill, `pc`=0x400 (same index 0) → refill 0x400–0x40C;
  - then `pc`=0x0 → `hit`=0 and a new refill from 0x0.
- Stall: in REFILL with `cnt`=1, hold `rdy`=0 for 3 cycles with `mem_ack`=1 → `mem_addr` and `cnt` unchanged; the ack is consumed on the first edge with `rdy`=1.
- Redirect: during the 0x0 refill, change `pc` to 0x20 → refill of 0x0–0xC completes; then a miss starts at 0x20; line 0x0 still hits.
- Async reset mid-refill: drop `rst` between edges after 2 acks → `mem_req`=0 immediately; after release, `pc`=0x0 misses and refill restarts at 0x0.
